// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit launch FSM states and buffering defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } tx_state_t;

  localparam int unsigned TX_START_TIMEOUT = 4;
  localparam int unsigned UART_TX_DEPTH    = 16;
  localparam int unsigned TX_TMO_W         = $clog2(TX_START_TIMEOUT) + 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy flags; read data is the entry at the
// read pointer, so a popping consumer samples dout on the same edge it pops.
module sync_fifo #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [AW:0]      level_nxt_c;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop_c    = pop && !empty;
    do_push_c   = push && (!full || do_pop_c);
    level_nxt_c = level;
    if (do_push_c && !do_pop_c) begin
      level_nxt_c = level + LW'(1);
    end else if (!do_push_c && do_pop_c) begin
      level_nxt_c = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(DEPTH));
      empty <= (level_nxt_c == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the CPU write port and the UART core: queues bytes and
// launches them one frame at a time, with a sticky overflow flag for dropped writes.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = UART_TX_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          writeenable,
  input  logic [31:0]   writedata,
  input  logic          clear_overflow,
  input  logic          tx_busy,
  output logic          transmit,
  output logic [7:0]    tx_byte,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  tx_state_t           state;
  tx_state_t           state_nxt;
  logic [TX_TMO_W-1:0] tmo_cnt;
  logic                pop_c;
  logic                drop_c;
  logic [7:0]          fifo_dout;
  logic                unused_wdata_c;

  assign unused_wdata_c = ^writedata[31:8];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (writeenable),
    .pop   (pop_c),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // START gives up after the timeout so a core that never raises busy cannot stall the queue.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop_c) state_nxt = START;
      START: begin
        if (tx_busy)                                           state_nxt = BUSY;
        else if (tmo_cnt == TX_TMO_W'(TX_START_TIMEOUT - 1))   state_nxt = IDLE;
      end
      BUSY:    if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_c  = 1'b0;
    drop_c = 1'b0;
    if (state == IDLE && !empty && !tx_busy) pop_c = 1'b1;
    if (writeenable && full && !pop_c)       drop_c = 1'b1;
  end

  // A drop in the same cycle as clear_overflow leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
      tmo_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      transmit <= pop_c;
      if (pop_c) tx_byte <= fifo_dout;
      if (pop_c)               tmo_cnt <= '0;
      else if (state == START) tmo_cnt <= tmo_cnt + TX_TMO_W'(1);
      if (drop_c)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural UART busy model plus a launch log checked
// against queues of expected bytes and timing derived from the launch rules.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        writeenable = 1'b0;
  logic [31:0] writedata = '0;
  logic        clear_overflow = 1'b0;
  logic        man_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        auto_busy = 1'b0;
  logic        tx_busy;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_left = 0;
  logic tx_prev = 1'b0;

  typedef struct {
    int         c;
    logic [7:0] b;
  } launch_t;
  launch_t tx_log[$];

  uart_tx_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .writeenable    (writeenable),
    .writedata      (writedata),
    .clear_overflow (clear_overflow),
    .tx_busy        (tx_busy),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .level          (level),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  assign tx_busy = auto_busy ? model_busy : man_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor: every cycle with transmit high is one frame start.
  always @(negedge clk) begin
    launch_t e;
    tx_prev = transmit;
    if (transmit) begin
      e.c = cyc;
      e.b = tx_byte;
      tx_log.push_back(e);
    end
  end

  // UART core model: busy for 10 cycles, starting one cycle after each launch.
  always @(posedge clk) begin
    #1;
    if (!auto_busy) begin
      model_busy = 1'b0;
      busy_left  = 0;
    end else if (busy_left > 0) begin
      busy_left  = busy_left - 1;
      model_busy = (busy_left > 0);
    end else if (tx_prev) begin
      model_busy = 1'b1;
      busy_left  = 10;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    writeenable = 1'b0;
    clear_overflow = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (tx_log.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit: got %b expected 0", transmit); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_single();
    auto_busy = 1'b0;
    man_busy = 1'b0;
    do_reset();
    tx_log.delete();
    writeenable = 1'b1;
    writedata = 32'hFFFF_FF41;
    tick(1);
    writeenable = 1'b0;
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1: got %0d expected 1", level); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty0: got %b expected 0", empty); end
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL single_early_tx: got %b expected 0", transmit); end
    tick(1);
    checks++; if (transmit !== 1'b1) begin errors++; $display("FAIL single_tx: got %b expected 1", transmit); end
    checks++; if (tx_byte !== 8'h41) begin errors++; $display("FAIL single_byte: got %h expected 41", tx_byte); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level0: got %0d expected 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty1: got %b expected 1", empty); end
    tick(1);
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b expected 0", transmit); end
    checks++; if (tx_byte !== 8'h41) begin errors++; $display("FAIL single_hold: got %h expected 41", tx_byte); end
    tick(10);
    checks++; if (tx_log.size() !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", tx_log.size()); end
  endtask

  task automatic test_burst();
    bit ok;
    auto_busy = 1'b1;
    do_reset();
    tx_log.delete();
    writeenable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      writedata = {24'($urandom), 8'(i)};
      tick(1);
    end
    writeenable = 1'b0;
    wait_log(5, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_launches: got %0d expected 5", tx_log.size()); end
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (tx_log[i].b !== 8'(i + 1)) begin
          errors++; $display("FAIL burst_order[%0d]: got %h expected %h", i, tx_log[i].b, 8'(i + 1));
        end
        if (i > 0) begin
          // busy fell after cycle prior_launch+11; next launch needs 2 more cycles
          checks++;
          if (tx_log[i].c - (tx_log[i-1].c + 11) < 2) begin
            errors++; $display("FAIL burst_gap[%0d]: got %0d expected >=2", i, tx_log[i].c - (tx_log[i-1].c + 11));
          end
        end
      end
    end
    tick(20);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty: got %b expected 1", empty); end
    checks++; if (tx_log.size() !== 5) begin errors++; $display("FAIL burst_extra: got %0d expected 5", tx_log.size()); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] exp_q[$];
    auto_busy = 1'b0;
    man_busy = 1'b1;
    do_reset();
    tx_log.delete();
    writeenable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      writedata = {24'($urandom), 8'(8'h10 + i)};
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      tick(1);
    end
    writeenable = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (tx_log.size() !== 0) begin errors++; $display("FAIL ovf_no_tx: got %0d expected 0", tx_log.size()); end
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    // Busy drops while full and a write arrives in the same cycle as the pop.
    man_busy = 1'b0;
    writeenable = 1'b1;
    writedata = {24'($urandom), 8'hAA};
    exp_q.push_back(8'hAA);
    tick(1);
    writeenable = 1'b0;
    auto_busy = 1'b1;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL pp_level: got %0d expected 16", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
    checks++; if (transmit !== 1'b1) begin errors++; $display("FAIL pp_tx: got %b expected 1", transmit); end
    checks++; if (tx_byte !== 8'h10) begin errors++; $display("FAIL pp_byte: got %h expected 10", tx_byte); end
    wait_log(17, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pp_launches: got %0d expected 17", tx_log.size()); end
    if (ok) begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (tx_log[i].b !== exp_q[i]) begin
          errors++; $display("FAIL pp_order[%0d]: got %h expected %h", i, tx_log[i].b, exp_q[i]);
        end
      end
    end
    tick(30);
    checks++; if (tx_log.size() !== 17) begin errors++; $display("FAIL pp_dropped_sent: got %0d expected 17", tx_log.size()); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] b0, b1;
    auto_busy = 1'b0;
    man_busy = 1'b0;
    do_reset();
    tx_log.delete();
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    writeenable = 1'b1;
    writedata = {24'($urandom), b0};
    tick(1);
    writedata = {24'($urandom), b1};
    tick(1);
    writeenable = 1'b0;
    wait_log(2, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_launches: got %0d expected 2", tx_log.size()); end
    if (ok) begin
      checks++; if (tx_log[1].c - tx_log[0].c !== 5) begin errors++; $display("FAIL tmo_spacing: got %0d expected 5", tx_log[1].c - tx_log[0].c); end
      checks++; if (tx_log[0].b !== b0) begin errors++; $display("FAIL tmo_byte0: got %h expected %h", tx_log[0].b, b0); end
      checks++; if (tx_log[1].b !== b1) begin errors++; $display("FAIL tmo_byte1: got %h expected %h", tx_log[1].b, b1); end
    end
    tick(10);
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [7:0] exp_q[$];
    auto_busy = 1'b1;
    do_reset();
    tx_log.delete();
    n = $urandom_range(6, 12);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 3));
      writeenable = 1'b1;
      writedata = $urandom;
      exp_q.push_back(writedata[7:0]);
      tick(1);
      writeenable = 1'b0;
    end
    wait_log(n, 20 * n + 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_launches: got %0d expected %0d", tx_log.size(), n); end
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (tx_log[i].b !== exp_q[i]) begin
          errors++; $display("FAIL rand_order[%0d]: got %h expected %h", i, tx_log[i].b, exp_q[i]);
        end
        if (i > 0) begin
          checks++;
          if (tx_log[i].c - tx_log[i-1].c < 13) begin
            errors++; $display("FAIL rand_spacing[%0d]: got %0d expected >=13", i, tx_log[i].c - tx_log[i-1].c);
          end
        end
      end
    end
    tick(20);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rand_level: got %0d expected 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_midframe();
    int k = 0;
    auto_busy = 1'b1;
    do_reset();
    tx_log.delete();
    writeenable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      writedata = $urandom;
      tick(1);
    end
    writeenable = 1'b0;
    while (!model_busy && k < 20) begin
      tick(1);
      k++;
    end
    checks++; if (!model_busy) begin errors++; $display("FAIL mid_busy_seen: got %b expected 1", model_busy); end
    tick(1);
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL mid_level_pre: got %0d expected 3", level); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tx_log.delete();
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL mid_transmit: got %b expected 0", transmit); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL mid_tx_byte: got %h expected 00", tx_byte); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    tick(40);
    checks++; if (tx_log.size() !== 0) begin errors++; $display("FAIL mid_no_tx: got %0d expected 0", tx_log.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
